// File: rtl/multi_trigger.sv
// multi_trigger: N-channel pulse generator driven by the broadcast frame stream.
// Type-2 frames load a channel's shadow config, type-1 frames copy shadow to
// active and carry the pulse ID that every enabled channel tests against its
// divider/modulus. Matching channels emit one pulse of programmable delay and
// length. Optional build macro MULTI_TRIGGER_RETRIGGER_EN: a match while a
// channel is busy restarts its delay/pulse instead of being ignored.

package multi_trigger_pkg;
  typedef struct packed {
    logic [7:0]  board;
    logic [7:0]  channel;
    logic [31:0] delay;
    logic [31:0] length;
    logic [31:0] divider;
    logic [31:0] modulus;
    logic [7:0]  status;
  } delay_data_t;

  localparam int DATA_W = $bits(delay_data_t);

  typedef struct packed {
    logic [7:0]        payload_type;
    logic [DATA_W-1:0] data;
  } payload_t;
endpackage

module multi_trigger
  import multi_trigger_pkg::*;
#(
  parameter int N_CHANNELS = 8,
  parameter int BOARD_ID   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  payload_t              payload_i,
  input  logic                  frame_tick_i,
  output logic [N_CHANNELS-1:0] pulse_o,
  output logic [N_CHANNELS-1:0] busy_o
);

`ifdef MULTI_TRIGGER_RETRIGGER_EN
  localparam logic RETRIG_EN = 1'b1;
`else
  localparam logic RETRIG_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  typedef struct packed {
    logic             en;
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] len;
    logic [31:0]      div;
    logic [31:0]      modv;
  } cfg_t;

  // Delay/length wider than the counters clamp to the largest count.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [31:0] v);
    logic [CNT_W-1:0] r;
    if ((v >> CNT_W) != 32'd0) begin
      r = {CNT_W{1'b1}};
    end else begin
      r = v[CNT_W-1:0];
    end
    return r;
  endfunction

  delay_data_t             dd_s;
  logic                    cfg_hit_s;
  logic                    id_hit_s;
  logic                    unused_status_s;
  logic [N_CHANNELS-1:0]   match_s;

  cfg_t                    shadow_q [N_CHANNELS];
  cfg_t                    shadow_d [N_CHANNELS];
  cfg_t                    active_q [N_CHANNELS];
  cfg_t                    active_d [N_CHANNELS];
  logic [31:0]             pulse_id_q, pulse_id_d;
  logic                    id_valid_q, id_valid_d;
  state_t                  state_q [N_CHANNELS];
  state_t                  state_d [N_CHANNELS];
  logic [CNT_W-1:0]        cnt_q [N_CHANNELS];
  logic [CNT_W-1:0]        cnt_d [N_CHANNELS];
  logic [CNT_W-1:0]        len_q [N_CHANNELS];
  logic [CNT_W-1:0]        len_d [N_CHANNELS];
  logic [N_CHANNELS-1:0]   pulse_q, pulse_d;
  logic [N_CHANNELS-1:0]   busy_q, busy_d;

  assign dd_s            = delay_data_t'(payload_i.data);
  assign unused_status_s = ^dd_s.status[7:1];

  // Frame decode: shadow writes on type-2, shadow->active copy and ID capture on type-1.
  always_comb begin
    cfg_hit_s  = frame_tick_i && (payload_i.payload_type == 8'd2) &&
                 (dd_s.board == 8'(BOARD_ID)) &&
                 ({24'd0, dd_s.channel} < 32'(N_CHANNELS));
    id_hit_s   = frame_tick_i && (payload_i.payload_type == 8'd1);
    pulse_id_d = id_hit_s ? payload_i.data[31:0] : pulse_id_q;
    id_valid_d = id_hit_s;
    for (int c = 0; c < N_CHANNELS; c++) begin
      shadow_d[c] = shadow_q[c];
      if (cfg_hit_s && (dd_s.channel == 8'(c))) begin
        shadow_d[c].en   = dd_s.status[0];
        shadow_d[c].dly  = sat_cnt(dd_s.delay);
        shadow_d[c].len  = sat_cnt(dd_s.length);
        shadow_d[c].div  = dd_s.divider;
        shadow_d[c].modv = dd_s.modulus;
      end else begin
        shadow_d[c] = shadow_q[c];
      end
      active_d[c] = id_hit_s ? shadow_q[c] : active_q[c];
    end
  end

  // ID match against the freshly copied active config, one cycle after the frame.
  always_comb begin
    match_s = {N_CHANNELS{1'b0}};
    for (int c = 0; c < N_CHANNELS; c++) begin
      match_s[c] = id_valid_q && active_q[c].en && (active_q[c].div != 32'd0) &&
                   ((pulse_id_q % active_q[c].div) == active_q[c].modv);
    end
  end

  // Per-channel FSM next state; the match is registered straight into the state
  // so the registered outputs show the first DELAY/PULSE cycle two cycles after
  // the frame. A PULSE on its last count may re-arm so pulses can be gapless.
  always_comb begin
    pulse_d = {N_CHANNELS{1'b0}};
    busy_d  = {N_CHANNELS{1'b0}};
    for (int c = 0; c < N_CHANNELS; c++) begin
      logic arm;
      logic last;
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      len_d[c]   = len_q[c];
      arm        = match_s[c] && (active_q[c].len != CNT_ZERO);
      last       = (cnt_q[c] == CNT_ONE);
      case (state_q[c])
        ST_IDLE:  arm = arm;
        ST_DELAY: arm = arm && RETRIG_EN;
        ST_PULSE: arm = arm && (RETRIG_EN || last);
        default:  arm = 1'b0;
      endcase
      if (arm) begin
        len_d[c] = active_q[c].len;
        if (active_q[c].dly != CNT_ZERO) begin
          state_d[c] = ST_DELAY;
          cnt_d[c]   = active_q[c].dly;
        end else begin
          state_d[c] = ST_PULSE;
          cnt_d[c]   = active_q[c].len;
        end
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            state_d[c] = ST_IDLE;
          end
          ST_DELAY: begin
            if (last) begin
              state_d[c] = ST_PULSE;
              cnt_d[c]   = len_q[c];
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_ONE;
            end
          end
          ST_PULSE: begin
            if (last) begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = CNT_ZERO;
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_ONE;
            end
          end
          default: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = CNT_ZERO;
          end
        endcase
      end
      pulse_d[c] = (state_d[c] == ST_PULSE);
      busy_d[c]  = (state_d[c] != ST_IDLE);
    end
  end

  // State, config and output registers; reset clears config so all channels disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_id_q <= 32'd0;
      id_valid_q <= 1'b0;
      pulse_q    <= {N_CHANNELS{1'b0}};
      busy_q     <= {N_CHANNELS{1'b0}};
      for (int c = 0; c < N_CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
        state_q[c]  <= ST_IDLE;
        cnt_q[c]    <= CNT_ZERO;
        len_q[c]    <= CNT_ZERO;
      end
    end else begin
      pulse_id_q <= pulse_id_d;
      id_valid_q <= id_valid_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      for (int c = 0; c < N_CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        len_q[c]    <= len_d[c];
      end
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule
